gpu_cmd_sequencer: RTL and testbench

//   Front-end controller for tt_um_pongsagon_tiniest_gpu. Takes byte-serial scene commands
//   (triangle vertex/colour bytes) over a valid/ready handshake and buffers them in shadow registers.

---
 rtl/gpu_cmd_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_gpu_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_sequencer.sv
// gpu_cmd_sequencer: command front-end for the tiniest GPU.
// Collects byte-serial scene packets into shadow registers and commits
// them to the live scene only on a vertical-blank rising edge. Each commit
// then starts the rasterizer setup stage with a start/busy handshake.
// Optional feature macro: SEQ_AUTOREPEAT_EN re-issues the setup on every
// vblank rise while idle, so the unchanged scene is redrawn each frame.
module gpu_cmd_sequencer #(
  parameter int NUM_REGS = 12,
  parameter int DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [DATA_W-1:0]          cmd_data,
  input  logic                       cmd_valid,
  input  logic                       cmd_last,
  output logic                       cmd_ready,
  input  logic                       vblank,
  output logic                       setup_start,
  input  logic                       setup_busy,
  output logic [NUM_REGS*DATA_W-1:0] scene_q,
  output logic [3:0]                 wr_idx,
  output logic [7:0]                 frame_cnt,
  output logic                       err_overrun
);

  // The index counts up to NUM_REGS inclusive, which needs 5 bits when
  // NUM_REGS is 16; the port shows a saturated 4-bit view.
  localparam logic [4:0] FULL_IDX = 5'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PENDING = 2'd2,
    ST_SETUP   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [4:0]        idx;
  logic [4:0]        idx_nx;
  logic              first;
  logic              first_nx;
  logic              start_nx;
  logic              wr_en;
  logic              err_set;
  logic              commit;
  logic              frame_inc;
  logic              vblank_d;
  logic              rise;
  logic              accept;
  logic [DATA_W-1:0] shadow [NUM_REGS];

  // Ready only in the collecting states; held low while reset is asserted.
  assign cmd_ready = ena & rst_n & ((state == ST_IDLE) | (state == ST_LOAD));
  assign accept    = cmd_valid & cmd_ready;
  assign rise      = vblank & ~vblank_d;
  assign wr_idx    = (idx > 5'd15) ? 4'hF : idx[3:0];

  // Next-state and datapath control decode; ena low freezes everything.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    first_nx  = first;
    start_nx  = 1'b0;
    wr_en     = 1'b0;
    err_set   = 1'b0;
    commit    = 1'b0;
    frame_inc = 1'b0;
    if (ena) begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            // Bytes past the last shadow slot are swallowed and flagged.
            if (idx < FULL_IDX) begin
              wr_en  = 1'b1;
              idx_nx = idx + 5'd1;
            end else begin
              err_set = 1'b1;
            end
            if (cmd_last) begin
              idx_nx   = 5'd0;
              state_nx = ST_PENDING;
            end else begin
              state_nx = ST_LOAD;
            end
          end
`ifdef SEQ_AUTOREPEAT_EN
          else if ((state == ST_IDLE) && (idx == 5'd0) && rise) begin
            // Redraw the already-committed scene without touching scene_q.
            start_nx = 1'b1;
            first_nx = 1'b1;
            state_nx = ST_SETUP;
          end
`endif
          else begin
            state_nx = state;
          end
        end
        ST_PENDING: begin
          if (rise) begin
            commit   = 1'b1;
            start_nx = 1'b1;
            first_nx = 1'b1;
            state_nx = ST_SETUP;
          end else begin
            state_nx = ST_PENDING;
          end
        end
        ST_SETUP: begin
          // The rasterizer cannot have raised busy yet on the start cycle.
          if (first) begin
            first_nx = 1'b0;
          end else if (!setup_busy) begin
            frame_inc = 1'b1;
            state_nx  = ST_IDLE;
          end else begin
            state_nx = ST_SETUP;
          end
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end else begin
      state_nx = state;
    end
  end

  // FSM state, write index, first-cycle flag and start pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= 5'd0;
      first       <= 1'b0;
      setup_start <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      first       <= first_nx;
      setup_start <= start_nx;
    end
  end

  // vblank delay for edge detection; tracks regardless of ena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblank_d <= 1'b0;
    end else begin
      vblank_d <= vblank;
    end
  end

  // Committed-frame counter, wraps naturally at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (frame_inc) begin
      frame_cnt <= frame_cnt + 8'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
    end else if (err_set) begin
      err_overrun <= 1'b1;
    end else begin
      err_overrun <= err_overrun;
    end
  end

  // Shadow byte writes; unwritten slots keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (idx == 5'(i))) begin
          shadow[i] <= cmd_data;
        end else begin
          shadow[i] <= shadow[i];
        end
      end
    end
  end

  // Live scene copy, loaded from the shadow only at a committing vblank rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_q <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        scene_q[i*DATA_W +: DATA_W] <= shadow[i];
      end
    end else begin
      scene_q <= scene_q;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Scoreboard bench for gpu_cmd_sequencer: each commit pushes the expected
// scene and frame count; a monitor pops and compares on every setup_start.
module tb_gpu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic [7:0]  cmd_data = 8'h00;
  logic        cmd_valid = 1'b0;
  logic        cmd_last = 1'b0;
  logic        cmd_ready;
  logic        vblank = 1'b0;
  logic        setup_start;
  logic        setup_busy = 1'b0;
  logic [95:0] scene_q;
  logic [3:0]  wr_idx;
  logic [7:0]  frame_cnt;
  logic        err_overrun;

  typedef struct {
    logic [95:0] scene;
    logic [7:0]  frame;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   exp_frame = 0;

  gpu_cmd_sequencer #(.NUM_REGS(12), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_last(cmd_last),
    .cmd_ready(cmd_ready), .vblank(vblank), .setup_start(setup_start),
    .setup_busy(setup_busy), .scene_q(scene_q), .wr_idx(wr_idx),
    .frame_cnt(frame_cnt), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  // Monitor: every setup_start must match the oldest expected commit.
  always @(negedge clk) begin
    if (rst_n && setup_start) begin
      exp_t e;
      start_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_start: setup_start seen with no commit expected");
      end else begin
        e = exp_q.pop_front();
        if (scene_q !== e.scene || frame_cnt !== e.frame) begin
          errors++;
          $display("FAIL commit: scene_q=%h frame_cnt=%0d, expected scene_q=%h frame_cnt=%0d",
                   scene_q, frame_cnt, e.scene, e.frame);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one byte and hold it until the sequencer takes it.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    cmd_data  = d;
    cmd_last  = l;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready_timeout", {95'd0, cmd_ready}, 96'd1);
    tick();
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  // Raise vblank, run the setup handshake and wait for the return to IDLE.
  task automatic do_commit(input logic [95:0] scene, input int busy_cycles);
    int n = 0;
    exp_q.push_back('{scene: scene, frame: 8'(exp_frame)});
    vblank = 1'b1;
    while (!setup_start && n < 20) begin
      tick();
      n++;
    end
    chk("start_timeout", {95'd0, setup_start}, 96'd1);
    vblank = 1'b0;
    if (busy_cycles > 0) setup_busy = 1'b1;
    tick();
    chk("start_one_cycle", {95'd0, setup_start}, 96'd0);
    chk("setup_first_cycle_held", {95'd0, cmd_ready}, 96'd0);
    for (int i = 1; i < busy_cycles; i++) tick();
    if (busy_cycles > 0) tick();
    setup_busy = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    exp_frame++;
    chk("frame_cnt", {88'd0, frame_cnt}, 96'(exp_frame));
    chk("idle_after_setup", {95'd0, cmd_ready}, 96'd1);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sc;
    // Reset state
    tick();
    tick();
    chk("rst_cmd_ready", {95'd0, cmd_ready}, 96'd0);
    chk("rst_scene_q", scene_q, 96'd0);
    chk("rst_frame_cnt", {88'd0, frame_cnt}, 96'd0);
    chk("rst_err", {95'd0, err_overrun}, 96'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", {95'd0, cmd_ready}, 96'd1);

    // Test 1: reset mid-LOAD discards the partial packet
    for (int i = 0; i < 5; i++) send_byte(8'h31 + 8'(i), 1'b0);
    chk("t1_wr_idx5", {92'd0, wr_idx}, 96'd5);
    rst_n = 1'b0;
    tick();
    tick();
    chk("t1_wr_idx", {92'd0, wr_idx}, 96'd0);
    chk("t1_scene", scene_q, 96'd0);
    chk("t1_frame", {88'd0, frame_cnt}, 96'd0);
    rst_n = 1'b1;
    #1;
    chk("t1_ready", {95'd0, cmd_ready}, 96'd1);

    // Test 2: full 12-byte packet, busy for 3 cycles
    for (int i = 0; i < 12; i++) send_byte(8'h01 + 8'(i), (i == 11));
    chk("t2_wr_idx", {92'd0, wr_idx}, 96'd0);
    chk("t2_pending", {95'd0, cmd_ready}, 96'd0);
    do_commit(96'h0C0B0A09_08070605_04030201, 3);
    chk("t2_err", {95'd0, err_overrun}, 96'd0);

    // Test 4: short packet keeps bytes 3..11; busy never asserted
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b1);
    do_commit(96'h0C0B0A09_08070605_04CCBBAA, 0);

    // Test 3: 14-byte packet overruns; extra bytes dropped
    for (int i = 0; i < 14; i++) begin
      send_byte(8'h10 + 8'(i), (i == 13));
      if (i == 12) begin
        chk("t3_wr_idx_sat", {92'd0, wr_idx}, 96'd12);
        chk("t3_err", {95'd0, err_overrun}, 96'd1);
      end
    end
    do_commit(96'h1B1A1918_17161514_13121110, 2);
    chk("t3_err_sticky", {95'd0, err_overrun}, 96'd1);

    // Test 5: byte held during PENDING/SETUP is taken only after IDLE
    send_byte(8'h77, 1'b1);
    cmd_data  = 8'h55;
    cmd_last  = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_not_ready", {95'd0, cmd_ready}, 96'd0);
    chk("t5_wr_idx", {92'd0, wr_idx}, 96'd0);
    do_commit(96'h1B1A1918_17161514_13121177, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t5_taken", {92'd0, wr_idx}, 96'd1);
    send_byte(8'h56, 1'b1);
    do_commit(96'h1B1A1918_17161514_13125655, 2);

    // ena low: rise while frozen in PENDING is lost
    send_byte(8'h99, 1'b1);
    ena = 1'b0;
    #1;
    chk("ena_ready_low", {95'd0, cmd_ready}, 96'd0);
    sc = start_cnt;
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    tick();
    chk("ena_no_start", 96'(start_cnt), 96'(sc));
    ena = 1'b1;
    tick();
    chk("ena_still_pending", {95'd0, cmd_ready}, 96'd0);
    do_commit(96'h1B1A1918_17161514_13125699, 1);

    // Test 6: vblank rise with nothing pending
`ifdef SEQ_AUTOREPEAT_EN
    do_commit(96'h1B1A1918_17161514_13125699, 1);
`else
    sc = start_cnt;
    vblank = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    vblank = 1'b0;
    tick();
    tick();
    chk("t6_no_start", 96'(start_cnt), 96'(sc));
    chk("t6_frame", {88'd0, frame_cnt}, 96'(exp_frame));
    chk("t6_idle", {95'd0, cmd_ready}, 96'd1);
`endif

    tick();
    chk("scoreboard_empty", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
